// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, Ready/FrameErr pulses.
// Define RX_MAJORITY_VOTE_EN to sample with a 3-value majority vote of the line.
module uart_receiver #(
    parameter logic [15:0] DIVIDER = 16'd5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       Ready,
    output logic       FrameErr,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic [15:0] HALF_LAST = (DIVIDER >> 1) - 16'd1;
    localparam logic [15:0] FULL_LAST = DIVIDER - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] tick_q, tick_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        frame_err_q, frame_err_d;

    logic        rx_meta_q, rx_meta_d;
    logic        line_q, line_d;
    logic        line_prev_q, line_prev_d;
    logic        sample;

    always_comb begin
        rx_meta_d   = RxD;
        line_d      = rx_meta_q;
        line_prev_d = line_q;
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic line_prev2_q, line_prev2_d;

    always_comb line_prev2_d = line_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) line_prev2_q <= 1'b0;
        else     line_prev2_q <= line_prev2_d;
    end

    assign sample = (line_q & line_prev_q) | (line_q & line_prev2_q) | (line_prev_q & line_prev2_q);
`else
    assign sample = line_q;
`endif

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ready_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (line_prev_q && !line_q) state_d = START;
            end
            START: begin
                if (tick_q == HALF_LAST) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == FULL_LAST) begin
                    tick_d    = '0;
                    shift_d   = {sample, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (tick_q == FULL_LAST) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (sample) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                tick_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            rx_meta_q   <= 1'b0;
            line_q      <= 1'b0;
            line_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            frame_err_q <= frame_err_d;
            rx_meta_q   <= rx_meta_d;
            line_q      <= line_d;
            line_prev_q <= line_prev_d;
        end
    end

    assign data     = data_q;
    assign Ready    = ready_q;
    assign FrameErr = frame_err_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (DIVIDER=16): a frame-level timing model
// predicts Busy/Ready/FrameErr/data per cycle and is compared every cycle.
module tb_uart_receiver;

    localparam int BIT  = 16;
    localparam int MAXC = 4096;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic [7:0] data;
    logic       Ready;
    logic       FrameErr;
    logic       Busy;

    uart_receiver #(.DIVIDER(16'd16)) dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .data     (data),
        .Ready    (Ready),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit       exp_ready [MAXC];
    bit       exp_ferr  [MAXC];
    bit       exp_busy  [MAXC];
    bit [7:0] exp_val   [MAXC];
    bit [7:0] model_data = 8'h00;

    int n_cmp = 0;
    int n_bad = 0;
    int seen_ready = 0;
    int seen_ferr  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    // A frame whose start edge is driven right after edge p is seen as a line
    // fall at edge p+3; the stop bit is sampled 152 cycles later.
    task automatic sched_frame(input int p, input logic [7:0] b, input logic stop);
        for (int c = p + 3; c <= p + 154; c++) exp_busy[c] = 1'b1;
        if (stop) begin
            exp_ready[p + 155] = 1'b1;
            exp_val[p + 155]   = b;
        end else begin
            exp_ferr[p + 155] = 1'b1;
        end
    endtask

    task automatic clear_future(input int from);
        for (int c = from; c < MAXC; c++) begin
            exp_ready[c] = 1'b0;
            exp_ferr[c]  = 1'b0;
            exp_busy[c]  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives ncyc cycles of an 8N1 frame; glitch_bit (0..9) inverts one cycle mid-bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            int   i;
            int   c;
            logic v;
            i = k / BIT;
            c = k % BIT;
            if (i == 0)      v = 1'b0;
            else if (i <= 8) v = b[i-1];
            else             v = stop;
            RxD = v ^ ((i == glitch_bit) && (c == 8));
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        logic er, ef, eb;
        if (rst) begin
            model_data = 8'h00;
            er = 1'b0; ef = 1'b0; eb = 1'b0;
        end else if (cyc < MAXC) begin
            er = exp_ready[cyc];
            ef = exp_ferr[cyc];
            eb = exp_busy[cyc];
            if (er) model_data = exp_val[cyc];
        end else begin
            er = 1'b0; ef = 1'b0; eb = 1'b0;
        end
        if (Ready === 1'b1)    seen_ready++;
        if (FrameErr === 1'b1) seen_ferr++;
        check("Ready",    {7'd0, Ready},    {7'd0, er});
        check("FrameErr", {7'd0, FrameErr}, {7'd0, ef});
        check("Busy",     {7'd0, Busy},     {7'd0, eb});
        check("data",     data,             model_data);
    end

    initial begin
        int p;
        logic [7:0] glitch_exp;
        rst = 1'b1;
        RxD = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_data",  data,              8'h00);
        check("reset_ready", {7'd0, Ready},     8'h00);
        check("reset_ferr",  {7'd0, FrameErr},  8'h00);
        check("reset_busy",  {7'd0, Busy},      8'h00);

        // Line held low across reset release must not start a frame.
        rst = 1'b0;
        idle(30);
        check("low_after_reset_busy", {7'd0, Busy}, 8'h00);
        RxD = 1'b1;
        idle(20);

        p = cyc; sched_frame(p, 8'h55, 1'b1);
        send_frame(8'h55, 1'b1, -1, 10 * BIT);
        check("frame55_data", data, 8'h55);
        idle(20);

        // 4-cycle low pulse: start bit rejected at the half-bit sample.
        p = cyc;
        for (int c = p + 3; c <= p + 10; c++) exp_busy[c] = 1'b1;
        RxD = 1'b0;
        idle(4);
        RxD = 1'b1;
        idle(30);
        check("glitch_start_data", data, 8'h55);

        // Framing error followed by a held-low break.
        p = cyc; sched_frame(p, 8'hA3, 1'b0);
        send_frame(8'hA3, 1'b0, -1, 10 * BIT);
        RxD = 1'b0;
        check("ferr_data_held", data, 8'h55);
        idle(40);
        check("break_busy", {7'd0, Busy}, 8'h00);
        RxD = 1'b1;
        idle(20);

        p = cyc; sched_frame(p, 8'h00, 1'b1);
        send_frame(8'h00, 1'b1, -1, 10 * BIT);
        check("b2b_first_data", data, 8'h00);
        p = cyc; sched_frame(p, 8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1, -1, 10 * BIT);
        check("b2b_second_data", data, 8'hFF);
        idle(20);

        // Reset in the middle of data bit 4 discards the partial byte.
        p = cyc; sched_frame(p, 8'h99, 1'b1);
        send_frame(8'h99, 1'b1, -1, 5 * BIT + 8);
        #2;
        rst = 1'b1;
        clear_future(cyc);
        #1;
        check("rst_imm_data",  data,             8'h00);
        check("rst_imm_ready", {7'd0, Ready},    8'h00);
        check("rst_imm_ferr",  {7'd0, FrameErr}, 8'h00);
        check("rst_imm_busy",  {7'd0, Busy},     8'h00);
        RxD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        p = cyc; sched_frame(p, 8'h3C, 1'b1);
        send_frame(8'h3C, 1'b1, -1, 10 * BIT);
        check("after_rst_data", data, 8'h3C);
        idle(20);

        // One-cycle high glitch at the data bit 0 sample point.
`ifdef RX_MAJORITY_VOTE_EN
        glitch_exp = 8'h00;
`else
        glitch_exp = 8'h01;
`endif
        p = cyc; sched_frame(p, glitch_exp, 1'b1);
        send_frame(8'h00, 1'b1, 1, 10 * BIT);
        check("glitch_bit0_data", data, glitch_exp);
        idle(20);

        check("ready_pulse_count", seen_ready[7:0], 8'd5);
        check("ferr_pulse_count",  seen_ferr[7:0],  8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter DIVIDER, default 16'd5208, meaning clk cycles per serial bit (50 MHz / 9600 bit/s), legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port RxD  input  1  serial line from the asynchronous sender; idle high; not synchronous to clk.
REQ-005 SHALL have port data  output  8  last correctly framed byte received.
REQ-006 SHALL have port Ready  output  1  one-cycle pulse when data has been updated.
REQ-007 SHALL have port FrameErr  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port Busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL pass RxD through a two-flop synchronizer before any use; the term "line" below means the synchronizer output.
REQ-010 SHALL use a 16-bit tick counter and a 3-bit bit index; the tick counter SHALL clear on every state change.
REQ-011 SHALL implement the states IDLE, START, DATA and STOP, registered, with a default branch to IDLE.
REQ-012 IDLE: SHALL go to START when a 1->0 transition of line is seen (previous cycle 1, current cycle 0); a line that stays low SHALL NOT trigger.
REQ-013 START: SHALL sample the line when tick == (DIVIDER>>1)-1; a sample of 0 SHALL go to DATA; a sample of 1 SHALL go to IDLE with no Ready or FrameErr (glitch rejection).
REQ-014 DATA: SHALL sample once every DIVIDER cycles (tick == DIVIDER-1) and shift the sample in LSB-first; after the 8th sample it SHALL go to STOP.
REQ-015 STOP: SHALL sample at tick == DIVIDER-1, which is mid-stop-bit, and then return to IDLE in the same edge.
REQ-016 A stop sample of 1 SHALL load data from the shift register and pulse Ready for exactly one cycle, registered at that edge.
REQ-017 A stop sample of 0 SHALL pulse FrameErr for exactly one cycle; data SHALL hold its previous value and Ready SHALL stay 0.
REQ-018 Ready and FrameErr SHALL never be high in the same cycle.
REQ-019 Back-to-back frames (start bit immediately after a 1-bit stop bit) SHALL be received without loss, because IDLE is re-entered half a bit before the end of the stop bit.
REQ-020 After a framing error with the line held low (break), the next frame SHALL be accepted only after the line rises and then falls (per REQ-012).

Reset
REQ-021 rst SHALL immediately force the state to IDLE and clear to 0: the tick counter, bit index, shift register, data, Ready and FrameErr; Busy follows the state and is therefore 0.
REQ-022 The synchronizer and edge-history flops SHALL reset to 0, so a line held low through reset release is not taken as a start bit.
REQ-023 A reset asserted mid-frame SHALL discard the partial byte with no Ready or FrameErr pulse.

Configuration
REQ-024 With `RX_MAJORITY_VOTE_EN defined, every sample point (start, data and stop) SHALL use the majority of the last three line values.
REQ-025 Without `RX_MAJORITY_VOTE_EN, every sample point SHALL use the single current line value.
REQ-026 The macro SHALL NOT change latency, ports or state transitions.

Verification (DIVIDER=16 for all scenarios)
REQ-027 Valid frame 0x55 with stop=1 -> data=0x55, Ready high for 1 cycle, FrameErr=0, Busy falls in the same cycle.
REQ-028 RxD low for 4 cycles from idle -> Busy pulses high, then returns to IDLE; no Ready, no FrameErr, data unchanged.
REQ-029 After 0x55, a frame 0xA3 with stop=0 -> FrameErr pulses for 1 cycle, Ready=0, data stays 0x55.
REQ-030 Frames 0x00 then 0xFF sent back-to-back -> two Ready pulses, with data 0x00 then 0xFF.
REQ-031 rst asserted during data bit 4 of a frame, then a fresh frame 0x3C -> all outputs 0 immediately, no pulse for the aborted frame, then data=0x3C with Ready.
REQ-032 Frame 0x00 with a 1-cycle high glitch at the data bit 0 sample point -> data=0x00 with `RX_MAJORITY_VOTE_EN defined; data=0x01 without it.
